// File: rtl/reg_file_pkg.sv
// Shared types and default parameter values for the multi-port register file
// and its pending-write scoreboard.
package reg_file_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_N_READ   = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker: reserve sets a bit, writeback clears it,
// flush empties the whole vector. Set wins over clear on the same address.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = DEF_ZERO_REG
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       flush,
  input  logic                       set_en,
  input  logic [ADDR_W-1:0]          set_addr,
  input  logic                       clr_en,
  input  logic [ADDR_W-1:0]          clr_addr,
  output logic [(2**ADDR_W)-1:0]     busy
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_nxt;

  // NOTE: every path starts from a full default so the comb block never infers a latch.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (clr_en) busy_nxt[clr_addr] = 1'b0;
      if (set_en) busy_nxt[set_addr] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) busy <= '0;
    else           busy <= busy_nxt;
  end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with a zeroing sweep after reset
// or clear, optional write-to-read bypass and a pending-write scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_READ   = DEF_N_READ,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                       clk,
  input  logic                       areset_n,
  input  logic                       clear,
  output logic                       ready,
  input  logic [N_READ*ADDR_W-1:0]   rd_addr,
  output logic [N_READ*DATA_W-1:0]   rd_data,
  output logic [N_READ-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);
  localparam bit BP    = (BYPASS != 0);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;
  logic              op_ok, wr_fire, rsv_fire;

  logic [DATA_W-1:0] mem [DEPTH];

  // Sweep sequencer: one location zeroed per edge, clear restarts from 0.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state <= ST_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      ST_CLEAR: begin
        if (clear) begin
          idx_nxt = '0;
        end else begin
          idx_nxt = idx + 1'b1;
          if (idx == {ADDR_W{1'b1}}) state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (clear) begin
          state_nxt = ST_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  assign ready    = (state == ST_READY);
  assign op_ok    = ready & ~clear;
  assign wr_fire  = op_ok & wr_en  & ~(ZR && (wr_addr  == '0));
  assign rsv_fire = op_ok & rsv_en & ~(ZR && (rsv_addr == '0));

  // NOTE: storage has no reset; the sweep rewrites every word before the file is usable.
  always_ff @(posedge clk) begin
    if (state == ST_CLEAR)  mem[idx]     <= '0;
    else if (wr_fire)       mem[wr_addr] <= wr_data;
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk      (clk),
    .areset_n (areset_n),
    .flush    (clear),
    .set_en   (rsv_fire),
    .set_addr (rsv_addr),
    .clr_en   (wr_fire),
    .clr_addr (wr_addr),
    .busy     (busy_vec)
  );

  // Independent read ports; a same-cycle legal write to the address is forwarded.
  for (genvar p = 0; p < N_READ; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              busy;

    assign addr = rd_addr[p*ADDR_W +: ADDR_W];

    always_comb begin
      data = '0;
      busy = 1'b0;
      if (ready && !(ZR && (addr == '0))) begin
        if (BP && wr_fire && (wr_addr == addr)) begin
          data = wr_data;
        end else begin
          data = mem[addr];
          busy = busy_vec[addr];
        end
      end
    end

    assign rd_data[p*DATA_W +: DATA_W] = data;
    assign rd_busy[p]                  = busy;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus random traffic,
// compared every cycle against an array-based model of the file.
module tb_reg_file_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             areset_n;
  logic             clear;
  logic             ready;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [DEPTH-1:0] busy_vec;

  reg_file_mp dut (
    .clk      (clk),
    .areset_n (areset_n),
    .clear    (clear),
    .ready    (ready),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy_vec (busy_vec)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: contents, busy flags, and edges left before the file is usable.
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;
  bit               m_ready;
  int               m_left;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_zero();
    m_ready = 1'b0;
    m_left  = DEPTH;
    m_busy  = '0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic model_edge();
    if (!m_ready) begin
      if (clear) m_left = DEPTH;
      else begin
        m_left--;
        if (m_left == 0) m_ready = 1'b1;
      end
    end else if (clear) begin
      model_zero();
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic check_outputs();
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          eb;
    check("ready", ready, m_ready);
    check("busy_vec", busy_vec, m_ready ? m_busy : '0);
    for (int p = 0; p < NR; p++) begin
      a  = rd_addr[p*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (m_ready && a != 0) begin
        if (wr_en && !clear && wr_addr == a) ed = wr_data;
        else begin
          ed = m_mem[a];
          eb = m_busy[a];
        end
      end
      check($sformatf("rd_data%0d@r%0d", p, a), rd_data[p*DW +: DW], ed);
      check($sformatf("rd_busy%0d@r%0d", p, a), rd_busy[p], eb);
    end
  endtask

  // Inputs are driven 1ns after a rising edge; outputs are sampled 2ns later.
  task automatic tick();
    #2;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr[0 +: AW]  = AW'(a0);
    rd_addr[AW +: AW] = AW'(a1);
  endtask

  task automatic read_all();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(a, DEPTH - 1 - a);
      tick();
    end
  endtask

  initial begin
    areset_n = 1'b0;
    idle();
    wr_addr = '0; wr_data = '0; rsv_addr = '0;
    set_rd(0, 0);
    model_zero();
    #3;
    check_outputs();
    @(posedge clk); @(posedge clk); #1;
    areset_n = 1'b1;

    // Sweep after reset: ready must rise on exactly the 32nd edge.
    for (int i = 0; i < DEPTH; i++) begin
      set_rd($urandom_range(0, 31), $urandom_range(0, 31));
      tick();
    end
    check("ready_after_sweep", ready, 1'b1);
    read_all();

    // Bypass of a same-cycle write, then registered read on the other port.
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; set_rd(5, 5);
    tick();
    idle(); set_rd(0, 5);
    tick();

    // Zero register ignores writes and reservations.
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
    rsv_en = 1'b1; rsv_addr = 0; set_rd(0, 0);
    tick();
    idle();
    tick();
    check("busy_vec0", busy_vec[0], 1'b0);

    // Reserve / writeback / same-cycle write+reserve on r7.
    rsv_en = 1'b1; rsv_addr = 7; set_rd(7, 7);
    tick();
    idle();
    tick();
    check("busy_vec7_set", busy_vec[7], 1'b1);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h55;
    tick();
    idle();
    tick();
    check("busy_vec7_clr", busy_vec[7], 1'b0);
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h66; rsv_en = 1'b1; rsv_addr = 7;
    tick();
    idle();
    tick();
    check("busy_vec7_wr_rsv", busy_vec[7], 1'b1);

    // Fill, clear, restart clear at sweep index 10.
    for (int i = 1; i < DEPTH; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = i; set_rd(i, i - 1);
      tick();
    end
    idle();
    rsv_en = 1'b1; rsv_addr = 9;
    tick();
    idle(); clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) tick();
    check("ready_before_restart_end", ready, 1'b0);
    tick();
    check("ready_after_restart", ready, 1'b1);
    read_all();

    // Asynchronous reset in the middle of a sweep.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    areset_n = 1'b0;
    #1;
    model_zero();
    check("ready_in_reset", ready, 1'b0);
    check("busy_in_reset", busy_vec, '0);
    @(posedge clk); #1;
    areset_n = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) tick();

    // Asynchronous reset while operating with reservations outstanding.
    rsv_en = 1'b1; rsv_addr = 3;
    tick();
    idle();
    areset_n = 1'b0;
    #1;
    model_zero();
    check("busy_mid_op_reset", busy_vec, '0);
    check("ready_mid_op_reset", ready, 1'b0);
    @(posedge clk); #1;
    areset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick();

    // Random traffic concentrated on a few registers to force collisions.
    for (int i = 0; i < 600; i++) begin
      wr_en    = $urandom_range(0, 1) == 1;
      wr_addr  = AW'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = $urandom_range(0, 3) == 0;
      rsv_addr = AW'($urandom_range(0, 7));
      clear    = $urandom_range(0, 99) == 0;
      if (clear) wr_en = 1'b0;
      set_rd(($urandom_range(0, 1) == 1) ? int'(wr_addr) : int'($urandom_range(0, 7)),
             int'($urandom_range(0, 7)));
      tick();
    end
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-read-port register file with hardware clear sequencer, optional write-to-read bypass and per-register pending-write scoreboard. It is the general-width/depth successor of the 32×32 register file and sits between decode (read/reserve) and writeback (write) in the processor datapath. The scoreboard lets multi-cycle producers mark a destination busy so that decode can stall on RAW hazards.

## Interface
- `DATA_W`, 32, register width in bits
- `ADDR_W`, 5, address width; depth `DEPTH = 2**ADDR_W`
- `N_READ`, 2, number of independent read ports (≥1)
- `ZERO_REG`, 1, 1 = register 0 hard-wired to zero, unwritable, never busy
- `BYPASS`, 1, 1 = same-cycle write data forwarded to matching read ports

- `clk` in 1 — single clock, rising edge
- `areset_n` in 1 — asynchronous, active-low reset
- `clear` in 1 — pulse: restart clear sweep
- `ready` out 1 — 1 when file is usable (not sweeping)
- `rd_addr` in `N_READ*ADDR_W` — port p address at bits `[p*ADDR_W +: ADDR_W]`
- `rd_data` out `N_READ*DATA_W` — port p data, same packing
- `rd_busy` out `N_READ` — port p addressed register has a pending write
- `wr_en` in 1 — write strobe
- `wr_addr` in `ADDR_W` — write address
- `wr_data` in `DATA_W` — write data
- `rsv_en` in 1 — reserve strobe (mark destination busy)
- `rsv_addr` in `ADDR_W` — register to reserve
- `busy_vec` out `DEPTH` — full scoreboard, bit i = register i busy

## Operation
- FSM states: `ST_CLEAR`, `ST_READY`. Reset and `clear` enter `ST_CLEAR` with sweep index 0.
- `ST_CLEAR`: each edge writes 0 to `mem[idx]`, idx++. After edge writing `DEPTH-1` → `ST_READY`. `clear` during sweep restarts idx at 0. `wr_en`/`rsv_en` ignored; all `rd_data`=0, `rd_busy`=0.
- `ST_READY`, `clear`=1: enter `ST_CLEAR`, clear entire scoreboard; same-cycle write/reserve dropped.
- Write: `ready & wr_en`, and not (`ZERO_REG` & `wr_addr`==0) → `mem[wr_addr] <= wr_data`, `busy[wr_addr] <= 0`.
- Reserve: `ready & rsv_en`, same zero-register exclusion → `busy[rsv_addr] <= 1`.
- Write and reserve to same address same cycle: data written, busy ends 1 (new producer wins).
- Write to non-busy register is legal; busy stays 0.
- Read port p: `ZERO_REG` & addr 0 → 0. Else if `BYPASS & ready & wr_en` & `wr_addr`==addr (and write legal) → `wr_data`, `rd_busy`=0. Else `mem[addr]`, `rd_busy`=`busy[addr]`.
- All read ports independent; any number may hit same address.

## Timing
- Reset values: `ready`=0, `busy_vec`=0, `rd_busy`=0, `rd_data`=0, FSM `ST_CLEAR`, idx 0.
- Reset deasserted → `ready` rises after exactly `DEPTH` rising edges (32 for defaults).
- Read latency 0 (combinational from `rd_addr`/state/memory).
- Write visible at read ports next cycle; same cycle when `BYPASS`=1.
- Reserve visible on `busy_vec`/`rd_busy` the cycle after `rsv_en`.
- `areset_n` asserted mid-sweep or mid-operation: immediate return to reset values; storage contents irrelevant since sweep rewrites all.

## Structure
- Package `reg_file_pkg`: state enum (`ST_CLEAR`, `ST_READY`), default parameter constants.
- Sub-module `reg_scoreboard`: `DEPTH`-bit busy vector with set/clear/flush inputs, zero-register mask; instantiated once.
- Storage, sweep FSM and read muxes (generate loop over `N_READ`) in top.

## Test plan
- Reset release → `ready`=0 for 32 cycles, 1 on 32nd edge; every address reads 0, `busy_vec`=0.
- Write 0xDEADBEEF to r5 → same-cycle `rd_data` port 0 at r5 = 0xDEADBEEF (BYPASS); next cycle port 1 at r5 = 0xDEADBEEF.
- Write 0x12345678 to r0 and reserve r0 → r0 reads 0, `busy_vec[0]`=0.
- Reserve r7 → next cycle `busy_vec[7]`=1, `rd_busy` for r7 =1; write r7 with 0x55 → next cycle busy 0, reads 0x55; same-cycle write+reserve r7 → busy stays 1.
- Fill r1..r31 with index value, pulse `clear` → `ready`=0, scoreboard 0, after 32 edges all reads 0; `clear` re-pulsed at idx 10 extends sweep to 32 edges from that pulse.
- Assert `areset_n`=0 at sweep idx 15 → `ready`/`busy_vec` 0 immediately; release → full 32-cycle sweep.
